// File: rtl/rsa_uart_sequencer_pkg.sv
// rsa_uart_pkg: shared types and constants for the RSA/UART sequencer.
//   - UART register map (byte addresses on the Avalon bus) and status bits
//   - byte counts for key/ciphertext loads (32) and plaintext output (31)
//   - sequencer state and load-phase enums
package rsa_uart_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;

  localparam int IN_BYTES  = 32;
  localparam int OUT_BYTES = 31;

  typedef enum logic [2:0] {
    ST_QUERY_RX,
    ST_READ_RX,
    ST_CALC,
    ST_WAIT_CORE,
    ST_QUERY_TX,
    ST_WRITE_TX
  } state_t;

  typedef enum logic [1:0] {
    PH_N,
    PH_E,
    PH_DATA
  } phase_t;

endpackage

// File: rtl/rsa_uart_sequencer_if.sv
// rsa_uart_sequencer_if: Avalon-MM bus between the sequencer (master) and the
// UART peripheral (slave).
//   address     master->slave  5   register byte address
//   read/write  master->slave  1   request strobes, never both high
//   writedata   master->slave  32  TX byte in [7:0], upper bits zero
//   readdata    slave->master  32  RX byte / status bits
//   waitrequest slave->master  1   stall
//
// Handshake: a request (read or write high) with its address and writedata is
// held unchanged while waitrequest is high; the transfer completes in the first
// cycle the request is high and waitrequest is low, readdata is valid in that
// same cycle, the request drops the following cycle, and at least one idle
// cycle separates consecutive transfers.
interface rsa_uart_sequencer_if;
  logic [4:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/rsa_uart_sequencer_avm_single_xfer.sv
// avm_single_xfer: issues one Avalon-MM transfer at a time.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_go           launch a transfer (ignored while one is in flight)
//   i_wr           1 = write, 0 = read
//   i_addr/i_wdata address and write data captured at launch
//   avm            master side of the bus (all outputs registered)
//   o_busy         a request is on the bus
//   o_done         one-cycle strobe in the accept cycle
//   o_rdata        read byte, valid while o_done is high
module avm_single_xfer
  import rsa_uart_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_go,
  input  logic                        i_wr,
  input  logic [4:0]                  i_addr,
  input  logic [31:0]                 i_wdata,
  rsa_uart_sequencer_if.master        avm,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [7:0]                  o_rdata
);

  // Busy is derived from the request strobes themselves, so after an accept the
  // strobes drop and the next launch can only land one cycle later: this gives
  // the mandatory idle cycle without an extra state bit.
  assign o_busy  = avm.read | avm.write;
  assign o_done  = o_busy & ~avm.waitrequest;
  assign o_rdata = avm.readdata[7:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      avm.address   <= STATUS_BASE;
      avm.read      <= 1'b0;
      avm.write     <= 1'b0;
      avm.writedata <= '0;
    end else if (o_busy) begin
      if (!avm.waitrequest) begin
        avm.read  <= 1'b0;
        avm.write <= 1'b0;
      end
    end else if (i_go) begin
      avm.address   <= i_addr;
      avm.read      <= ~i_wr;
      avm.write     <= i_wr;
      avm.writedata <= i_wdata;
    end
  end

endmodule

// File: rtl/rsa_uart_sequencer.sv
// rsa_uart_sequencer: loads modulus n and exponent e (32 bytes each, MSB
// first) from a polled UART, then per block receives a 32-byte ciphertext,
// runs the RSA core and transmits the low 31 result bytes, MSB first.
//   i_clk, i_rst        clock, synchronous active-high reset
//   avm                 Avalon-MM master to the UART
//   o_core_start        one-cycle start pulse
//   o_core_a/e/n        ciphertext, exponent, modulus to the core
//   i_core_result       core result, captured on i_core_finished
//   i_core_finished     core done pulse (only honoured while waiting for it)
//   o_dbg_state         current sequencer state
//   o_dbg_phase         current load phase
module rsa_uart_sequencer
  import rsa_uart_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  rsa_uart_sequencer_if.master  avm,
  output logic                  o_core_start,
  output logic [255:0]          o_core_a,
  output logic [255:0]          o_core_e,
  output logic [255:0]          o_core_n,
  input  logic [255:0]          i_core_result,
  input  logic                  i_core_finished,
  output state_t                o_dbg_state,
  output phase_t                o_dbg_phase
);

  localparam logic [5:0] LAST_IN_CNT  = 6'(IN_BYTES - 1);
  localparam logic [5:0] TX_FIRST_CNT = 6'(OUT_BYTES - 1);

  state_t         state_r;
  phase_t         phase_r;
  logic [5:0]     cnt_r;
  logic [255:0]   n_r, e_r, a_r, result_r;
  logic           start_r;

  logic           xfer_go, xfer_wr, xfer_busy, xfer_done;
  logic [4:0]     xfer_addr;
  logic [31:0]    xfer_wdata;
  logic [7:0]     xfer_rdata;

  avm_single_xfer u_xfer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_go    (xfer_go),
    .i_wr    (xfer_wr),
    .i_addr  (xfer_addr),
    .i_wdata (xfer_wdata),
    .avm     (avm),
    .o_busy  (xfer_busy),
    .o_done  (xfer_done),
    .o_rdata (xfer_rdata)
  );

  // Request selection. In WAIT_CORE the first TX status poll is launched on
  // the finished pulse itself so it reaches the bus together with result_r.
  always_comb begin
    xfer_go    = 1'b0;
    xfer_wr    = 1'b0;
    xfer_addr  = STATUS_BASE;
    xfer_wdata = '0;
    case (state_r)
      ST_QUERY_RX, ST_QUERY_TX: xfer_go = 1'b1;
      ST_READ_RX: begin
        xfer_go   = 1'b1;
        xfer_addr = RX_BASE;
      end
      ST_WRITE_TX: begin
        xfer_go    = 1'b1;
        xfer_wr    = 1'b1;
        xfer_addr  = TX_BASE;
        xfer_wdata = {24'h0, result_r[{cnt_r[4:0], 3'b000} +: 8]};
      end
      ST_WAIT_CORE: xfer_go = i_core_finished;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= ST_QUERY_RX;
      phase_r  <= PH_N;
      cnt_r    <= '0;
      n_r      <= '0;
      e_r      <= '0;
      a_r      <= '0;
      result_r <= '0;
      start_r  <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        ST_QUERY_RX: begin
          if (xfer_done && xfer_rdata[RX_OK_BIT]) state_r <= ST_READ_RX;
        end
        ST_READ_RX: begin
          if (xfer_done) begin
            // New byte enters as LSB so the first byte sent ends up as MSB.
            case (phase_r)
              PH_N:    n_r <= {n_r[247:0], xfer_rdata};
              PH_E:    e_r <= {e_r[247:0], xfer_rdata};
              default: a_r <= {a_r[247:0], xfer_rdata};
            endcase
            if (cnt_r == LAST_IN_CNT) begin
              cnt_r <= '0;
              if (phase_r == PH_DATA) begin
                state_r <= ST_CALC;
                start_r <= 1'b1;
              end else begin
                phase_r <= (phase_r == PH_N) ? PH_E : PH_DATA;
                state_r <= ST_QUERY_RX;
              end
            end else begin
              cnt_r   <= cnt_r + 6'd1;
              state_r <= ST_QUERY_RX;
            end
          end
        end
        ST_CALC: state_r <= ST_WAIT_CORE;
        ST_WAIT_CORE: begin
          if (i_core_finished) begin
            result_r <= i_core_result;
            cnt_r    <= TX_FIRST_CNT;
            state_r  <= ST_QUERY_TX;
          end
        end
        ST_QUERY_TX: begin
          if (xfer_done && xfer_rdata[TX_OK_BIT]) state_r <= ST_WRITE_TX;
        end
        ST_WRITE_TX: begin
          if (xfer_done) begin
            if (cnt_r == '0) begin
              phase_r <= PH_DATA;
              cnt_r   <= '0;
              state_r <= ST_QUERY_RX;
            end else begin
              cnt_r   <= cnt_r - 6'd1;
              state_r <= ST_QUERY_TX;
            end
          end
        end
        default: state_r <= ST_QUERY_RX;
      endcase
    end
  end

  assign o_core_start = start_r;
  assign o_core_a     = a_r;
  assign o_core_e     = e_r;
  assign o_core_n     = n_r;
  assign o_dbg_state  = state_r;
  assign o_dbg_phase  = phase_r;

endmodule
